// File: rtl/gps_track_pkg.sv
// Shared tracking-scheduler types and constants: channel count, integration limit, FSM states.
// Pure declarations; no latency, no backpressure.
package gps_track_pkg;
    localparam int NUM_CH_DEF     = 4;
    localparam int CH_W_DEF       = $clog2(NUM_CH_DEF);
    localparam int MAX_INT_EPOCHS = 20;
    localparam int EPOCH_W        = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

    // Zero means a single epoch; anything past the limit saturates.
    function automatic logic [EPOCH_W-1:0] clamp_int(input logic [EPOCH_W-1:0] v);
        if (v == '0)
            return EPOCH_W'(1);
        else if (v > EPOCH_W'(MAX_INT_EPOCHS))
            return EPOCH_W'(MAX_INT_EPOCHS);
        else
            return v;
    endfunction
endpackage

// File: rtl/gps_rr_arbiter.sv
// Combinational round-robin pick: first set pend bit at or after rr_ptr, wrapping.
// Zero latency; no backpressure, the caller decides when to take the grant.
module gps_rr_arbiter
    import gps_track_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pend,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_vld
);
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        // Walk from farthest to nearest so the closest requester is the last writer.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (pend[idx]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
    end
endmodule

// File: rtl/gps_dump_scheduler.sv
// Integrate-and-dump controller: dump strobe 1 cycle after the closing epoch, round-robin feed to one loop filter.
// Holds lf_valid/lf_ch until lf_ready; waits for lf_done, aborting after LF_TIMEOUT cycles.
module gps_dump_scheduler
    import gps_track_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int CH_W       = $clog2(NUM_CH),
    parameter int LF_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [4:0]         int_epochs,
    input  logic [NUM_CH-1:0]  ch_active,
    input  logic [NUM_CH-1:0]  ch_epoch,
    output logic [NUM_CH-1:0]  ch_dump,
    output logic               lf_valid,
    output logic [CH_W-1:0]    lf_ch,
    input  logic               lf_ready,
    input  logic               lf_done,
    output logic [NUM_CH-1:0]  overrun,
    output logic               timeout_err,
    input  logic               err_clr,
    output logic               busy
);
    localparam int TMO_W = $clog2(LF_TIMEOUT + 1);

    logic                enable_q;
    logic [EPOCH_W-1:0]  int_q;
    logic [EPOCH_W-1:0]  int_eff;
    logic [EPOCH_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0]   pend;
    logic [NUM_CH-1:0]   dump_ev;
    logic [NUM_CH-1:0]   hs_clr;
    logic                hs;
    sched_state_t        state;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [CH_W-1:0]     rr_ptr;
    logic [CH_W-1:0]     grant_idx;
    logic                grant_vld;
    logic [CH_W-1:0]     ch_next;

    // The enabling cycle already integrates against the freshly latched length.
    assign int_eff = (enable && !enable_q) ? clamp_int(int_epochs) : int_q;
    assign hs      = (state == GRANT) && lf_valid && lf_ready;
    assign ch_next = (lf_ch == CH_W'(NUM_CH - 1)) ? '0 : lf_ch + CH_W'(1);
    assign busy    = (state != IDLE) || (|pend);

    always_comb begin
        dump_ev = '0;
        hs_clr  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            dump_ev[i] = enable && ch_active[i] && ch_epoch[i]
                         && (cnt[i] == int_eff - EPOCH_W'(1));
            hs_clr[i]  = hs && (lf_ch == CH_W'(i));
        end
    end

    gps_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .pend      (pend),
        .rr_ptr    (rr_ptr),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable_q <= 1'b0;
            int_q    <= EPOCH_W'(1);
            pend     <= '0;
            ch_dump  <= '0;
            overrun  <= '0;
            for (int i = 0; i < NUM_CH; i++)
                cnt[i] <= '0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q)
                int_q <= clamp_int(int_epochs);
            ch_dump <= dump_ev;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!enable || !ch_active[i])
                    cnt[i] <= '0;
                else if (ch_epoch[i])
                    cnt[i] <= dump_ev[i] ? '0 : cnt[i] + EPOCH_W'(1);

                // A fresh dump outranks the handshake clear of the previous one.
                if (!ch_active[i])
                    pend[i] <= 1'b0;
                else if (dump_ev[i])
                    pend[i] <= 1'b1;
                else if (hs_clr[i])
                    pend[i] <= 1'b0;

                if (dump_ev[i] && pend[i] && !hs_clr[i])
                    overrun[i] <= 1'b1;
                else if (err_clr)
                    overrun[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            lf_valid    <= 1'b0;
            lf_ch       <= '0;
            rr_ptr      <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (err_clr)
                timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        lf_ch    <= grant_idx;
                        lf_valid <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (lf_ready) begin
                        lf_valid <= 1'b0;
                        tmo_cnt  <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (lf_done) begin
                        rr_ptr <= ch_next;
                        state  <= IDLE;
                    end else if (tmo_cnt == TMO_W'(LF_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        rr_ptr      <= ch_next;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    lf_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gps_dump_scheduler.sv
// Directed bench for gps_dump_scheduler with hand-computed expectations.
module tb_gps_dump_scheduler;
    localparam int NUM_CH     = 4;
    localparam int CH_W       = 2;
    localparam int LF_TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [4:0]        int_epochs;
    logic [NUM_CH-1:0] ch_active;
    logic [NUM_CH-1:0] ch_epoch;
    logic [NUM_CH-1:0] ch_dump;
    logic              lf_valid;
    logic [CH_W-1:0]   lf_ch;
    logic              lf_ready;
    logic              lf_done;
    logic [NUM_CH-1:0] overrun;
    logic              timeout_err;
    logic              err_clr;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gps_dump_scheduler #(
        .NUM_CH     (NUM_CH),
        .CH_W       (CH_W),
        .LF_TIMEOUT (LF_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .int_epochs  (int_epochs),
        .ch_active   (ch_active),
        .ch_epoch    (ch_epoch),
        .ch_dump     (ch_dump),
        .lf_valid    (lf_valid),
        .lf_ch       (lf_ch),
        .lf_ready    (lf_ready),
        .lf_done     (lf_done),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] m);
        ch_epoch = m;
        cyc(1);
        ch_epoch = '0;
    endtask

    // Entry: request expected on lf_valid. Accept, hold done off 2 cycles, then done.
    task automatic serve(input logic [CH_W-1:0] ch, input string tag);
        chk({tag, "_valid"}, 32'(lf_valid), 32'd1);
        chk({tag, "_ch"}, 32'(lf_ch), 32'(ch));
        lf_ready = 1'b1;
        cyc(1);
        lf_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(lf_valid), 32'd0);
        cyc(2);
        lf_done = 1'b1;
        cyc(1);
        lf_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; enable = 1'b0; int_epochs = 5'd1; ch_active = '0;
        ch_epoch = '0; lf_ready = 1'b0; lf_done = 1'b0; err_clr = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        chk("rst_dump", 32'(ch_dump), 32'd0);
        chk("rst_valid", 32'(lf_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);

        // 1: single-epoch integration on ch0
        enable = 1'b1; ch_active = 4'b0001;
        cyc(1);
        for (int it = 0; it < 3; it++) begin
            cyc(90);
            pulse(4'b0001);
            chk("t1_dump", 32'(ch_dump), 32'h1);
            cyc(1);
            chk("t1_dump_off", 32'(ch_dump), 32'h0);
            serve(2'd0, "t1");
        end

        // 2: 20-epoch integration on ch1
        enable = 1'b0; int_epochs = 5'd20; ch_active = 4'b0010;
        cyc(1);
        enable = 1'b1;
        cyc(1);
        for (int p = 1; p <= 20; p++) begin
            cyc(1);
            pulse(4'b0010);
            chk("t2_dump", 32'(ch_dump[1]), (p == 20) ? 32'd1 : 32'd0);
        end
        cyc(1);
        serve(2'd1, "t2a");
        n = 0;
        for (int p = 1; p <= 19; p++) begin
            cyc(1);
            pulse(4'b0010);
            n += int'(ch_dump[1]);
        end
        chk("t2_restart_quiet", 32'(n), 32'd0);
        cyc(1);
        pulse(4'b0010);
        chk("t2_restart_dump", 32'(ch_dump[1]), 32'd1);
        cyc(1);
        serve(2'd1, "t2b");

        // 3: round-robin from a clean pointer
        int_epochs = 5'd1;
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        ch_active = 4'b1111;
        pulse(4'b1111);
        chk("t3_dump_all", 32'(ch_dump), 32'hf);
        for (int c = 0; c < 4; c++) begin
            cyc(1);
            serve(CH_W'(c), "t3_rr");
        end
        pulse(4'b1001);
        cyc(1);
        serve(2'd0, "t3_wrap0");
        cyc(1);
        serve(2'd3, "t3_wrap3");
        cyc(1);
        chk("t3_idle", 32'(busy), 32'd0);

        // 4: overrun, single request, clear, set-wins, dump during handshake
        ch_active = 4'b0100;
        pulse(4'b0100);
        cyc(1);
        chk("t4_valid", 32'(lf_valid), 32'd1);
        cyc(3);
        pulse(4'b0100);
        chk("t4_overrun", 32'(overrun), 32'h4);
        serve(2'd2, "t4");
        cyc(1);
        chk("t4_no_second", 32'(lf_valid), 32'd0);
        chk("t4_idle", 32'(busy), 32'd0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t4_clr", 32'(overrun), 32'h0);
        pulse(4'b0100);
        cyc(1);
        err_clr = 1'b1;
        pulse(4'b0100);
        err_clr = 1'b0;
        chk("t4_set_wins", 32'(overrun), 32'h4);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t4_clr2", 32'(overrun), 32'h0);
        lf_ready = 1'b1; ch_epoch = 4'b0100;
        cyc(1);
        lf_ready = 1'b0; ch_epoch = '0;
        chk("t4_hs_dump_ovr", 32'(overrun), 32'h0);
        chk("t4_hs_dump_busy", 32'(busy), 32'd1);
        cyc(2);
        lf_done = 1'b1;
        cyc(1);
        lf_done = 1'b0;
        cyc(1);
        serve(2'd2, "t4_regrant");
        cyc(1);
        chk("t4_idle2", 32'(busy), 32'd0);

        // 5: loop filter never finishes
        ch_active = 4'b0011;
        pulse(4'b0011);
        cyc(1);
        chk("t5_valid", 32'(lf_valid), 32'd1);
        chk("t5_ch", 32'(lf_ch), 32'd0);
        lf_ready = 1'b1;
        cyc(1);
        lf_ready = 1'b0;
        cyc(LF_TIMEOUT - 1);
        chk("t5_not_yet", 32'(timeout_err), 32'd0);
        cyc(1);
        chk("t5_timeout", 32'(timeout_err), 32'd1);
        chk("t5_idle_valid", 32'(lf_valid), 32'd0);
        cyc(1);
        serve(2'd1, "t5_next");
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t5_clr", 32'(timeout_err), 32'd0);

        // 6: reset while a grant is outstanding
        ch_active = 4'b0110;
        pulse(4'b0110);
        cyc(1);
        chk("t6_valid", 32'(lf_valid), 32'd1);
        chk("t6_ch", 32'(lf_ch), 32'd2);
        reset_n = 1'b0; ch_epoch = 4'b0110;
        cyc(1);
        reset_n = 1'b1; ch_epoch = '0;
        chk("t6_valid_rst", 32'(lf_valid), 32'd0);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_dump_rst", 32'(ch_dump), 32'd0);

        // Integration length clamps
        enable = 1'b0; int_epochs = 5'd0; ch_active = 4'b0001;
        cyc(1);
        enable = 1'b1;
        cyc(1);
        pulse(4'b0001);
        chk("int0_dump", 32'(ch_dump), 32'h1);
        cyc(1);
        serve(2'd0, "int0");
        enable = 1'b0; int_epochs = 5'd31;
        cyc(1);
        enable = 1'b1;
        cyc(1);
        n = 0;
        for (int p = 1; p <= 19; p++) begin
            pulse(4'b0001);
            n += int'(ch_dump[0]);
        end
        chk("int31_quiet", 32'(n), 32'd0);
        pulse(4'b0001);
        chk("int31_dump", 32'(ch_dump), 32'h1);
        cyc(1);
        serve(2'd0, "int31");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
